// File: rtl/fbuf_write_arbiter_if.sv
// Write-side bus of the double-buffered framebuffer: two pixel requesters,
// fill/swap control, vertical-blanking flag and the BRAM write port.
// The requesters/controller drive through master; the arbiter sits on slave.
interface fbuf_write_arbiter_if #(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH      = 24
);

  // Timing generator
  logic                       eof;

  // Requester 0
  logic                       req0_valid;
  logic                       req0_ready;
  logic [FBUF_ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0]      req0_data;

  // Requester 1
  logic                       req1_valid;
  logic                       req1_ready;
  logic [FBUF_ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0]      req1_data;

  // Fill engine control
  logic                       fill_start;
  logic [DATA_WIDTH-1:0]      fill_color;
  logic                       fill_busy;

  // Buffer swap control
  logic                       swap_req;
  logic                       swap_pending;
  logic                       front_sel;

  // BRAM write port and error flag
  logic                       fbuf_we;
  logic [FBUF_ADDR_WIDTH:0]   fbuf_waddr;
  logic [DATA_WIDTH-1:0]      fbuf_wdata;
  logic                       addr_err;

  modport master (
    output eof,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output fill_start, fill_color,
    input  fill_busy,
    output swap_req,
    input  swap_pending, front_sel,
    input  fbuf_we, fbuf_waddr, fbuf_wdata, addr_err
  );

  modport slave (
    input  eof,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  fill_start, fill_color,
    output fill_busy,
    input  swap_req,
    output swap_pending, front_sel,
    output fbuf_we, fbuf_waddr, fbuf_wdata, addr_err
  );

endinterface

// File: rtl/fbuf_write_arbiter.sv
// Write-side controller of a double-buffered framebuffer. Round-robin shares the
// single BRAM write port between two requesters, runs a back-buffer clear engine
// and flips front/back buffers only on the rising edge of vertical blanking.
module fbuf_write_arbiter #(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH      = 24,
  parameter int unsigned FBUF_DEPTH      = 307200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fbuf_write_arbiter_if.slave   bus
);

  // One extra bit so FBUF_DEPTH == 2**FBUF_ADDR_WIDTH is still representable.
  localparam logic [FBUF_ADDR_WIDTH:0]   DepthW  = (FBUF_ADDR_WIDTH + 1)'(FBUF_DEPTH);
  localparam logic [FBUF_ADDR_WIDTH-1:0] LastCnt = FBUF_ADDR_WIDTH'(FBUF_DEPTH - 1);

  typedef enum logic [0:0] {
    StArb,
    StFill
  } state_e;

  state_e                     state_q;
  logic                       last_grant_q;   // 1: requester 1 was granted last
  logic                       eof_d_q;
  logic                       swap_pending_q;
  logic                       front_sel_q;
  logic                       fill_busy_q;
  logic [FBUF_ADDR_WIDTH-1:0] fill_cnt_q;
  logic [DATA_WIDTH-1:0]      fill_color_q;

  logic                       fbuf_we_q;
  logic [FBUF_ADDR_WIDTH:0]   fbuf_waddr_q;
  logic [DATA_WIDTH-1:0]      fbuf_wdata_q;
  logic                       addr_err_q;

  logic                       in_arb;
  logic                       eof_rise;
  logic                       pend_next;
  logic                       fill_accept;
  logic                       swap_cycle;
  logic                       arb_en;
  logic                       grant0;
  logic                       grant1;
  logic                       xfer;
  logic                       xfer_in_range;
  logic [FBUF_ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0]      xfer_data;

  // Arbitration: fill_start beats a swap, a swap beats the requesters.
  always_comb begin
    in_arb        = (state_q == StArb);
    eof_rise      = bus.eof & ~eof_d_q;
    pend_next     = swap_pending_q | bus.swap_req;
    fill_accept   = in_arb & bus.fill_start;
    swap_cycle    = in_arb & eof_rise & pend_next & ~bus.fill_start;
    arb_en        = in_arb & ~bus.fill_start & ~swap_cycle;
    // On a tie the requester that was not granted last wins.
    grant0        = arb_en & bus.req0_valid & (~bus.req1_valid | last_grant_q);
    grant1        = arb_en & bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    xfer          = grant0 | grant1;
    xfer_addr     = grant1 ? bus.req1_addr : bus.req0_addr;
    xfer_data     = grant1 ? bus.req1_data : bus.req0_data;
    xfer_in_range = ({1'b0, xfer_addr} < DepthW);
  end

  // Control FSM with registered write port, fill counter and swap bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StArb;
      last_grant_q   <= 1'b1;
      eof_d_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      front_sel_q    <= 1'b0;
      fill_busy_q    <= 1'b0;
      fill_cnt_q     <= '0;
      fill_color_q   <= '0;
      fbuf_we_q      <= 1'b0;
      fbuf_waddr_q   <= '0;
      fbuf_wdata_q   <= '0;
      addr_err_q     <= 1'b0;
    end else begin
      eof_d_q    <= bus.eof;
      fbuf_we_q  <= 1'b0;
      addr_err_q <= 1'b0;
      unique case (state_q)
        StArb: begin
          if (swap_cycle) begin
            front_sel_q    <= ~front_sel_q;
            swap_pending_q <= 1'b0;
          end else begin
            swap_pending_q <= pend_next;
          end
          if (fill_accept) begin
            state_q      <= StFill;
            fill_busy_q  <= 1'b1;
            fill_cnt_q   <= '0;
            fill_color_q <= bus.fill_color;
          end
          if (xfer) begin
            last_grant_q <= grant1;
            fbuf_waddr_q <= {~front_sel_q, xfer_addr};
            fbuf_wdata_q <= xfer_data;
            fbuf_we_q    <= xfer_in_range;
            addr_err_q   <= ~xfer_in_range;
          end
        end
        StFill: begin
          // Swaps wait; an eof rise seen here is consumed via eof_d_q.
          swap_pending_q <= pend_next;
          fbuf_we_q      <= 1'b1;
          fbuf_waddr_q   <= {~front_sel_q, fill_cnt_q};
          fbuf_wdata_q   <= fill_color_q;
          if (fill_cnt_q == LastCnt) begin
            state_q     <= StArb;
            fill_busy_q <= 1'b0;
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= StArb;
          fill_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.fill_busy    = fill_busy_q;
  assign bus.swap_pending = swap_pending_q;
  assign bus.front_sel    = front_sel_q;
  assign bus.fbuf_we      = fbuf_we_q;
  assign bus.fbuf_waddr   = fbuf_waddr_q;
  assign bus.fbuf_wdata   = fbuf_wdata_q;
  assign bus.addr_err     = addr_err_q;

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Bench for fbuf_write_arbiter at 16-pixel buffers, 5-bit addresses, 8-bit pixels.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered) or 1 ns after driving (combinational readies).
module tb_fbuf_write_arbiter;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fbuf_write_arbiter_if #(.FBUF_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fbuf_write_arbiter #(
    .FBUF_ADDR_WIDTH(AW),
    .DATA_WIDTH     (DW),
    .FBUF_DEPTH     (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic idle_inputs();
    bus.eof        = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
    bus.fill_start = 1'b0;
    bus.fill_color = '0;
    bus.swap_req   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({bus.fbuf_we, bus.addr_err, bus.fill_busy, bus.swap_pending, bus.front_sel,
         bus.req0_ready, bus.req1_ready} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000000", {bus.fbuf_we, bus.addr_err,
               bus.fill_busy, bus.swap_pending, bus.front_sel, bus.req0_ready, bus.req1_ready});
    end
    n_vec++;
    if (bus.fbuf_waddr !== 6'h00 || bus.fbuf_wdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_bus: got waddr=%h wdata=%h want 00/00", bus.fbuf_waddr, bus.fbuf_wdata);
    end
    // Single write from requester 0.
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd3;
    bus.req0_data  = 8'hAA;
    #1;
    n_vec++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_ready: got r0=%b r1=%b want 1/0", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_vec++;
    if (bus.fbuf_we !== 1'b1 || bus.fbuf_waddr !== 6'h23 || bus.fbuf_wdata !== 8'hAA) begin
      n_err++;
      $display("FAIL single_write: got we=%b waddr=%h wdata=%h want 1/23/aa",
               bus.fbuf_we, bus.fbuf_waddr, bus.fbuf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    logic [5:0] exp_addr [4];
    logic [7:0] exp_data [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_rdy     = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr[i] = (i % 2 == 0) ? 6'(32 + i) : 6'(32 + 8 + i);
      exp_data[i] = (i % 2 == 0) ? 8'(8'h10 + i) : 8'(8'h20 + i);
    end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_vec++;
        if (bus.fbuf_we !== 1'b1 || bus.fbuf_waddr !== exp_addr[i-1] ||
            bus.fbuf_wdata !== exp_data[i-1]) begin
          n_err++;
          $display("FAIL rr_write%0d: got we=%b waddr=%h wdata=%h want 1/%h/%h", i - 1,
                   bus.fbuf_we, bus.fbuf_waddr, bus.fbuf_wdata, exp_addr[i-1], exp_data[i-1]);
        end
      end
      if (i < 4) begin
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'(i);
        bus.req0_data  = 8'(8'h10 + i);
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 5'(8 + i);
        bus.req1_data  = 8'(8'h20 + i);
        #1;
        exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
        n_vec++;
        if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin
          n_err++;
          $display("FAIL rr_grant%0d: got r1r0=%b want %b", i,
                   {bus.req1_ready, bus.req0_ready}, exp_rdy);
        end
      end else begin
        idle_inputs();
      end
    end
  endtask

  task automatic test_addr_err();
    @(negedge clk);
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd16;
    bus.req1_data  = 8'h33;
    #1;
    n_vec++;
    if (bus.req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL oor_ready: got %b want 1", bus.req1_ready);
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    n_vec++;
    if (bus.fbuf_we !== 1'b0 || bus.addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL oor_err: got we=%b err=%b want 0/1", bus.fbuf_we, bus.addr_err);
    end
    @(negedge clk);
    n_vec++;
    if (bus.addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL oor_pulse: got err=%b want 0", bus.addr_err);
    end
  endtask

  task automatic test_fill();
    logic [13:0] wq[$];
    int          busy_cnt;
    int          ready_bad;
    bit          granted;
    @(negedge clk);
    bus.fill_start = 1'b1;
    bus.fill_color = 8'h5C;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd2;
    bus.req0_data  = 8'h77;
    #1;
    n_vec++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_start_rdy: got r0=%b r1=%b want 0/0", bus.req0_ready, bus.req1_ready);
    end
    busy_cnt  = 0;
    ready_bad = 0;
    granted   = 1'b0;
    for (int cyc = 1; cyc <= 40 && !granted; cyc++) begin
      @(negedge clk);
      if (bus.fill_busy === 1'b1) busy_cnt++;
      if (bus.fill_busy === 1'b1 && bus.req0_ready !== 1'b0) ready_bad++;
      if (bus.fbuf_we === 1'b1) wq.push_back({bus.fbuf_waddr, bus.fbuf_wdata});
      if (bus.fill_busy === 1'b0 && bus.req0_ready === 1'b1) granted = 1'b1;
      // A second fill_start mid-fill must be ignored.
      bus.fill_start = (cyc == 5);
      bus.fill_color = (cyc == 5) ? 8'h11 : 8'h5C;
    end
    n_vec++;
    if (!granted) begin
      n_err++;
      $display("FAIL fill_grant: got no grant within 40 cycles want grant");
    end
    n_vec++;
    if (busy_cnt != 16) begin
      n_err++;
      $display("FAIL fill_busy_len: got %0d want 16", busy_cnt);
    end
    n_vec++;
    if (ready_bad != 0) begin
      n_err++;
      $display("FAIL fill_ready_low: got %0d ready cycles want 0", ready_bad);
    end
    n_vec++;
    if (wq.size() != 16) begin
      n_err++;
      $display("FAIL fill_count: got %0d writes want 16", wq.size());
    end
    for (int k = 0; k < 16 && k < wq.size(); k++) begin
      n_vec++;
      if (wq[k] !== {6'(32 + k), 8'h5C}) begin
        n_err++;
        $display("FAIL fill_write%0d: got %h want %h", k, wq[k], {6'(32 + k), 8'h5C});
      end
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_vec++;
    if (bus.fbuf_we !== 1'b1 || bus.fbuf_waddr !== 6'h22 || bus.fbuf_wdata !== 8'h77) begin
      n_err++;
      $display("FAIL fill_after: got we=%b waddr=%h wdata=%h want 1/22/77",
               bus.fbuf_we, bus.fbuf_waddr, bus.fbuf_wdata);
    end
  endtask

  task automatic test_swap();
    @(negedge clk);
    bus.swap_req   = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd4;
    bus.req0_data  = 8'h44;
    @(negedge clk);
    bus.swap_req = 1'b0;
    n_vec++;
    if (bus.swap_pending !== 1'b1) begin
      n_err++;
      $display("FAIL swap_pend: got %b want 1", bus.swap_pending);
    end
    repeat (8) @(negedge clk);
    n_vec++;
    if (bus.swap_pending !== 1'b1 || bus.front_sel !== 1'b0) begin
      n_err++;
      $display("FAIL swap_wait: got pend=%b front=%b want 1/0", bus.swap_pending, bus.front_sel);
    end
    @(negedge clk);
    bus.eof = 1'b1;
    #1;
    n_vec++;
    if (bus.req0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL swap_nogrant: got r0=%b want 0", bus.req0_ready);
    end
    @(negedge clk);
    n_vec++;
    if (bus.front_sel !== 1'b1 || bus.swap_pending !== 1'b0 || bus.fbuf_we !== 1'b0 ||
        bus.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL swap_edge: got front=%b pend=%b we=%b r0=%b want 1/0/0/1",
               bus.front_sel, bus.swap_pending, bus.fbuf_we, bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_vec++;
    if (bus.fbuf_we !== 1'b1 || bus.fbuf_waddr !== 6'h04 || bus.fbuf_wdata !== 8'h44) begin
      n_err++;
      $display("FAIL swap_newback: got we=%b waddr=%h wdata=%h want 1/04/44",
               bus.fbuf_we, bus.fbuf_waddr, bus.fbuf_wdata);
    end
    @(negedge clk);
    bus.eof = 1'b0;
  endtask

  task automatic test_swap_during_fill();
    int  early_swaps;
    bit  done;
    @(negedge clk);
    bus.fill_start = 1'b1;
    bus.fill_color = 8'h66;
    @(negedge clk);
    bus.fill_start = 1'b0;
    bus.swap_req   = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    early_swaps  = 0;
    done         = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 2) bus.eof = 1'b1;
      if (bus.front_sel !== 1'b1) early_swaps++;
      if (bus.fill_busy === 1'b0) done = 1'b1;
    end
    n_vec++;
    if (!done || early_swaps != 0) begin
      n_err++;
      $display("FAIL swapfill_hold: got done=%b early=%0d want 1/0", done, early_swaps);
    end
    // eof still high after the fill: not a rise.
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.front_sel !== 1'b1 || bus.swap_pending !== 1'b1) begin
      n_err++;
      $display("FAIL swapfill_level: got front=%b pend=%b want 1/1",
               bus.front_sel, bus.swap_pending);
    end
    bus.eof = 1'b0;
    @(negedge clk);
    bus.eof = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.front_sel !== 1'b0 || bus.swap_pending !== 1'b0) begin
      n_err++;
      $display("FAIL swapfill_rise: got front=%b pend=%b want 0/0",
               bus.front_sel, bus.swap_pending);
    end
    bus.eof = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    bit hit;
    int stray;
    @(negedge clk);
    bus.fill_start = 1'b1;
    bus.fill_color = 8'h99;
    @(negedge clk);
    bus.fill_start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
      @(negedge clk);
      if (bus.fbuf_we === 1'b1 && bus.fbuf_waddr[4:0] === 5'd7) begin
        rst_n = 1'b0;
        hit   = 1'b1;
      end
    end
    #1;
    n_vec++;
    if (!hit || bus.fbuf_we !== 1'b0 || bus.fill_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstfill_abort: got hit=%b we=%b busy=%b want 1/0/0",
               hit, bus.fbuf_we, bus.fill_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (bus.fbuf_we !== 1'b0 || bus.fill_busy !== 1'b0) stray++;
    end
    n_vec++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL rstfill_quiet: got %0d active cycles want 0", stray);
    end
  endtask

  // Transaction-level model: a "preferred" requester wins ties and flips to
  // the other side after every grant; each accepted request yields one write
  // (or one error pulse) on the following cycle.
  task automatic test_random();
    int         pref;
    int         g;
    logic       v0, v1;
    logic [4:0] a0, a1, ga;
    logic [7:0] d0, d1, gd;
    logic       e_we, e_err;
    logic [5:0] e_waddr;
    logic [7:0] e_wdata;
    logic [1:0] e_rdy;
    do_reset();
    pref  = 0;
    e_we  = 1'b0;
    e_err = 1'b0;
    e_waddr = '0;
    e_wdata = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.fbuf_we !== e_we || bus.addr_err !== e_err ||
          (e_we && (bus.fbuf_waddr !== e_waddr || bus.fbuf_wdata !== e_wdata))) begin
        n_err++;
        $display("FAIL rand_write%0d: got we=%b err=%b waddr=%h wdata=%h want %b/%b/%h/%h", i,
                 bus.fbuf_we, bus.addr_err, bus.fbuf_waddr, bus.fbuf_wdata,
                 e_we, e_err, e_waddr, e_wdata);
      end
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = 5'($urandom_range(0, 19));
      a1 = 5'($urandom_range(0, 19));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      bus.req1_data  = d1;
      #1;
      if (v0 && v1) g = pref;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
      else          g = -1;
      e_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      n_vec++;
      if ({bus.req1_ready, bus.req0_ready} !== e_rdy) begin
        n_err++;
        $display("FAIL rand_grant%0d: got r1r0=%b want %b", i,
                 {bus.req1_ready, bus.req0_ready}, e_rdy);
      end
      if (g >= 0) begin
        pref    = (g == 0) ? 1 : 0;
        ga      = (g == 0) ? a0 : a1;
        gd      = (g == 0) ? d0 : d1;
        e_we    = (int'(ga) < DEPTH);
        e_err   = !(int'(ga) < DEPTH);
        e_waddr = {1'b1, ga};
        e_wdata = gd;
      end else begin
        e_we  = 1'b0;
        e_err = 1'b0;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_addr_err();
    test_fill();
    test_swap();
    test_swap_during_fill();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
